alu_sequencer: RTL and testbench

Multi-cycle controller that puts a single 4-bit ALU behind a valid/ready request interface and a held result interface.
- Single-cycle ops (logic, add, sub, shift) complete in 1 cycle.
- MUL runs as a 4-iteration shift-add; DIV runs as a 4-iteration restoring divide.
- Sits between an instruction issuer and the ALU datapath; owns opcode decode, operand capture, iteration counting and flag generation.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/seq_muldiv.sv | 72 +++++++
 rtl/alu_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_alu_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM states, mul/div mode.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 4;
    localparam int unsigned OPC_W     = 4;

    localparam logic [OPC_W-1:0] OP_AND  = 4'h0;
    localparam logic [OPC_W-1:0] OP_OR   = 4'h1;
    localparam logic [OPC_W-1:0] OP_XOR  = 4'h2;
    localparam logic [OPC_W-1:0] OP_XNOR = 4'h3;
    localparam logic [OPC_W-1:0] OP_NAND = 4'h4;
    localparam logic [OPC_W-1:0] OP_NOR  = 4'h5;
    localparam logic [OPC_W-1:0] OP_NOT  = 4'h6;
    localparam logic [OPC_W-1:0] OP_ADD  = 4'h7;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'h8;
    localparam logic [OPC_W-1:0] OP_SHL  = 4'h9;
    localparam logic [OPC_W-1:0] OP_SHR  = 4'hA;
    localparam logic [OPC_W-1:0] OP_MUL  = 4'hB;
    localparam logic [OPC_W-1:0] OP_DIV  = 4'hC;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    typedef enum logic {
        MD_MUL = 1'b0,
        MD_DIV = 1'b1
    } md_mode_t;

endpackage

// File: rtl/seq_muldiv.sv
// Iterative shift-add multiplier / restoring divider; one step per start or step pulse.
module seq_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step,
    input  md_mode_t         mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0] acc_q, q_q, m_q;
    md_mode_t         mode_q;

    logic [WIDTH-1:0] acc_s, q_s, m_s;
    md_mode_t         mode_s;
    logic [WIDTH-1:0] acc_n, q_n;
    logic [WIDTH:0]   sum, rem, diff;

    // start applies the first step directly to freshly loaded operands
    always_comb begin
        acc_s  = acc_q;
        q_s    = q_q;
        m_s    = m_q;
        mode_s = mode_q;
        if (start) begin
            acc_s  = '0;
            mode_s = mode;
            q_s    = (mode == MD_MUL) ? b : a;
            m_s    = (mode == MD_MUL) ? a : b;
        end

        sum  = {1'b0, acc_s} + (q_s[0] ? {1'b0, m_s} : '0);
        rem  = {acc_s, q_s[WIDTH-1]};
        diff = rem - {1'b0, m_s};

        if (mode_s == MD_MUL) begin
            acc_n = sum[WIDTH:1];
            q_n   = {sum[0], q_s[WIDTH-1:1]};
        end else if (!diff[WIDTH]) begin
            acc_n = diff[WIDTH-1:0];
            q_n   = {q_s[WIDTH-2:0], 1'b1};
        end else begin
            acc_n = rem[WIDTH-1:0];
            q_n   = {q_s[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q  <= '0;
            q_q    <= '0;
            m_q    <= '0;
            mode_q <= MD_MUL;
        end else if (start || step) begin
            acc_q  <= acc_n;
            q_q    <= q_n;
            m_q    <= m_s;
            mode_q <= mode_s;
        end
    end

    assign hi = acc_q;
    assign lo = q_q;

endmodule

// File: rtl/alu_sequencer.sv
// Valid/ready front end for a 4-bit ALU with multi-cycle MUL/DIV and held results.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPC_W-1:0] opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_err
);

    localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             out_valid_d, in_ready_d;
    logic [WIDTH-1:0] res_lo_d, res_hi_d;
    logic             flag_c_d, flag_z_d, flag_err_d;
    logic             res_load;

    logic             md_start, md_step;
    md_mode_t         md_mode;
    logic [WIDTH-1:0] md_hi, md_lo;

    logic [WIDTH:0]   add_sum, sub_diff;
    logic [WIDTH-1:0] sc_lo;
    logic             sc_c;

    seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (md_start),
        .step  (md_step),
        .mode  (md_mode),
        .a     (a),
        .b     (b),
        .hi    (md_hi),
        .lo    (md_lo)
    );

    // Single-cycle logic, adder and shifter results
    always_comb begin
        add_sum  = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
        sub_diff = {1'b0, a} - {1'b0, b};
        sc_c     = 1'b0;
        case (opcode)
            OP_AND:  sc_lo = a & b;
            OP_OR:   sc_lo = a | b;
            OP_XOR:  sc_lo = a ^ b;
            OP_XNOR: sc_lo = ~(a ^ b);
            OP_NAND: sc_lo = ~(a & b);
            OP_NOR:  sc_lo = ~(a | b);
            OP_NOT:  sc_lo = ~a;
            OP_ADD: begin
                sc_lo = add_sum[WIDTH-1:0];
                sc_c  = add_sum[WIDTH];
            end
            OP_SUB: begin
                sc_lo = sub_diff[WIDTH-1:0];
                sc_c  = sub_diff[WIDTH];
            end
            OP_SHL:  sc_lo = a << b[1:0];
            OP_SHR:  sc_lo = a >> b[1:0];
            default: sc_lo = '0;
        endcase
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        out_valid_d = out_valid;
        res_lo_d    = res_lo;
        res_hi_d    = res_hi;
        flag_c_d    = flag_c;
        flag_z_d    = flag_z;
        flag_err_d  = flag_err;
        res_load    = 1'b0;
        md_start    = 1'b0;
        md_step     = 1'b0;
        md_mode     = MD_MUL;

        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    case (opcode)
                        OP_MUL: begin
                            md_start = 1'b1;
                            md_mode  = MD_MUL;
                            cnt_d    = '0;
                            state_d  = S_MUL;
                        end
                        OP_DIV: begin
                            if (b == '0) begin
                                res_lo_d   = '1;
                                res_hi_d   = a;
                                flag_c_d   = 1'b0;
                                flag_err_d = 1'b1;
                                res_load   = 1'b1;
                            end else begin
                                md_start = 1'b1;
                                md_mode  = MD_DIV;
                                cnt_d    = '0;
                                state_d  = S_DIV;
                            end
                        end
                        default: begin
                            // Illegal opcodes fall through with sc_lo = 0
                            res_lo_d   = sc_lo;
                            res_hi_d   = '0;
                            flag_c_d   = sc_c;
                            flag_err_d = (opcode > OP_DIV);
                            res_load   = 1'b1;
                        end
                    endcase
                end
            end
            S_MUL, S_DIV: begin
                if (cnt == CNT_W'(ITER-1)) begin
                    res_lo_d   = md_lo;
                    res_hi_d   = md_hi;
                    flag_c_d   = 1'b0;
                    flag_err_d = 1'b0;
                    res_load   = 1'b1;
                end else begin
                    md_step = 1'b1;
                    cnt_d   = cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (res_load) begin
            flag_z_d    = ({res_hi_d, res_lo_d} == '0);
            out_valid_d = 1'b1;
            state_d     = S_DONE;
        end
        in_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            res_lo    <= '0;
            res_hi    <= '0;
            flag_c    <= 1'b0;
            flag_z    <= 1'b0;
            flag_err  <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            res_lo    <= res_lo_d;
            res_hi    <= res_hi_d;
            flag_c    <= flag_c_d;
            flag_z    <= flag_z_d;
            flag_err  <= flag_err_d;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed vector bench for alu_sequencer: table of ops plus backpressure and reset sequences.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] opcode;
    logic [3:0] a, b;
    logic       cin;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] res_lo, res_hi;
    logic       flag_c, flag_z, flag_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] lo;
        logic [3:0] hi;
        logic       c;
        logic       z;
        logic       err;
        int         edges;
    } vec_t;

    vec_t vecs[$];

    alu_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res_lo    (res_lo),
        .res_hi    (res_hi),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .flag_err  (flag_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a request and return just after the accepting edge; operands then scrambled.
    task automatic issue(input logic [3:0] op, input logic [3:0] av, input logic [3:0] bv,
                         input logic cv);
        int t = 0;
        while (!in_ready && t < 50) begin
            tick();
            t++;
        end
        chk("in_ready before issue", 32'(in_ready), 32'd1);
        opcode   = op;
        a        = av;
        b        = bv;
        cin      = cv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        opcode   = 4'h7;
        a        = 4'($urandom);
        b        = 4'($urandom);
        cin      = 1'($urandom);
    endtask

    // Edges after the accepting edge until out_valid is seen; flags any in_ready while waiting.
    task automatic wait_result(output int edges, output logic ready_low);
        edges     = 0;
        ready_low = 1'b1;
        while (!out_valid && edges < 40) begin
            if (in_ready) ready_low = 1'b0;
            tick();
            edges++;
        end
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, " out_valid after accept"}, 32'(out_valid), 32'd0);
        chk({tag, " in_ready after accept"}, 32'(in_ready), 32'd1);
    endtask

    task automatic chk_result(input string tag, input logic [3:0] lo, input logic [3:0] hi,
                              input logic c, input logic z, input logic err);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, " res_lo"}, 32'(res_lo), 32'(lo));
        chk({tag, " res_hi"}, 32'(res_hi), 32'(hi));
        chk({tag, " flag_c"}, 32'(flag_c), 32'(c));
        chk({tag, " flag_z"}, 32'(flag_z), 32'(z));
        chk({tag, " flag_err"}, 32'(flag_err), 32'(err));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " res_lo"}, 32'(res_lo), 32'd0);
        chk({tag, " res_hi"}, 32'(res_hi), 32'd0);
        chk({tag, " flags"}, 32'({flag_c, flag_z, flag_err}), 32'd0);
    endtask

    initial begin
        int   edges;
        logic ready_low;
        string tag;

        // op, a, b, cin, lo, hi, c, z, err, edges-to-valid
        vecs.push_back('{4'h0, 4'b1101, 4'b1010, 1'b0, 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0, 0});
        vecs.push_back('{4'h1, 4'b1101, 4'b1010, 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 0});
        vecs.push_back('{4'h2, 4'b1101, 4'b1010, 1'b0, 4'b0111, 4'b0000, 1'b0, 1'b0, 1'b0, 0});
        vecs.push_back('{4'h3, 4'b1101, 4'b1010, 1'b0, 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0, 0});
        vecs.push_back('{4'h4, 4'b1101, 4'b1010, 1'b0, 4'b0111, 4'b0000, 1'b0, 1'b0, 1'b0, 0});
        vecs.push_back('{4'h5, 4'b1101, 4'b1010, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 0});
        vecs.push_back('{4'h6, 4'b1101, 4'b1010, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 0});
        vecs.push_back('{4'h7, 4'b1101, 4'b1010, 1'b0, 4'b0111, 4'b0000, 1'b1, 1'b0, 1'b0, 0});
        vecs.push_back('{4'h7, 4'b0001, 4'b0010, 1'b1, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 0});
        vecs.push_back('{4'h7, 4'b1111, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 0});
        vecs.push_back('{4'h8, 4'b0101, 4'b0101, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 0});
        vecs.push_back('{4'h8, 4'b1001, 4'b0011, 1'b0, 4'b0110, 4'b0000, 1'b0, 1'b0, 1'b0, 0});
        vecs.push_back('{4'h9, 4'b1010, 4'b0010, 1'b0, 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0, 0});
        vecs.push_back('{4'hA, 4'b1010, 4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 0});
        vecs.push_back('{4'h9, 4'b0011, 4'b0111, 1'b0, 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0, 0});
        vecs.push_back('{4'hB, 4'b1101, 4'b1010, 1'b0, 4'b0010, 4'b1000, 1'b0, 1'b0, 1'b0, 4});
        vecs.push_back('{4'hB, 4'b1111, 4'b1111, 1'b1, 4'b0001, 4'b1110, 1'b0, 1'b0, 1'b0, 4});
        vecs.push_back('{4'hB, 4'b0000, 4'b0101, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 4});
        vecs.push_back('{4'hC, 4'b1010, 4'b0011, 1'b0, 4'b0011, 4'b0001, 1'b0, 1'b0, 1'b0, 4});
        vecs.push_back('{4'hC, 4'b1111, 4'b0001, 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 4});
        vecs.push_back('{4'hC, 4'b0010, 4'b0111, 1'b0, 4'b0000, 4'b0010, 1'b0, 1'b0, 1'b0, 4});
        vecs.push_back('{4'hC, 4'b0111, 4'b0000, 1'b0, 4'b1111, 4'b0111, 1'b0, 1'b0, 1'b1, 0});
        vecs.push_back('{4'hF, 4'b1101, 4'b1010, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 0});
        vecs.push_back('{4'hD, 4'b1111, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 0});

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opcode    = 4'h0;
        a         = 4'h0;
        b         = 4'h0;
        cin       = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk_all_zero("reset");
        chk("reset in_ready", 32'(in_ready), 32'd1);

        foreach (vecs[i]) begin
            tag = $sformatf("v%0d op%0h", i, vecs[i].op);
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
            wait_result(edges, ready_low);
            chk({tag, " latency"}, 32'(edges), 32'(vecs[i].edges));
            if (vecs[i].edges > 0) chk({tag, " in_ready low while busy"}, 32'(ready_low), 32'd1);
            chk_result(tag, vecs[i].lo, vecs[i].hi, vecs[i].c, vecs[i].z, vecs[i].err);
            consume(tag);
        end

        // Backpressure: SUB result held, new requests ignored while DONE
        issue(4'h8, 4'b0011, 4'b0101, 1'b0);
        wait_result(edges, ready_low);
        chk("bp latency", 32'(edges), 32'd0);
        for (int k = 0; k < 3; k++) begin
            opcode   = 4'h7;
            a        = 4'b0001;
            b        = 4'b0001;
            in_valid = (k == 0);
            tick();
            in_valid = 1'b0;
            tag = $sformatf("bp hold%0d", k);
            chk_result(tag, 4'b1110, 4'b0000, 1'b1, 1'b0, 1'b0);
            chk({tag, " in_ready"}, 32'(in_ready), 32'd0);
        end
        consume("bp");
        tick();
        chk("bp ignored request out_valid", 32'(out_valid), 32'd0);
        chk("bp result kept after leave", 32'(res_lo), 32'b1110);

        // Reset in the middle of a divide abandons it
        issue(4'hC, 4'b1111, 4'b0010, 1'b0);
        tick();
        tick();
        chk("rst mid-op still busy", 32'({out_valid, in_ready}), 32'd0);
        rst_n = 1'b0;
        tick();
        chk_all_zero("rst mid-op");
        rst_n = 1'b1;
        tick();
        chk("rst release in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 5; k++) tick();
        chk_all_zero("rst abandoned");

        issue(4'h2, 4'b1100, 4'b1010, 1'b0);
        wait_result(edges, ready_low);
        chk("post-rst xor latency", 32'(edges), 32'd0);
        chk_result("post-rst xor", 4'b0110, 4'b0000, 1'b0, 1'b0, 1'b0);
        consume("post-rst xor");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
